// File: rtl/sr_latch_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sr_latch_driver                                            |
// | Description : Write driver for an external active-low SR latch. A write  |
// |               request pulses exactly one of S/R low for PULSE_W cycles,  |
// |               waits SETTLE cycles, then compares the synchronized latch  |
// |               outputs against the written value and reports done/err.    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk        in   single clock, rising edge                              |
// |   rst        in   synchronous active-high reset                          |
// |   req_valid  in   write request present                                  |
// |   req_bit    in   value to store (1 = Q high)                            |
// |   req_ready  out  request can be accepted this cycle                     |
// |   S          out  active-low latch input, low drives Q=0                 |
// |   R          out  active-low latch input, low drives Q=1                 |
// |   Q          in   latch true output (asynchronous)                       |
// |   Qbar       in   latch complement output (asynchronous)                 |
// |   done       out  one-cycle pulse, write verified                        |
// |   err        out  one-cycle pulse, readback mismatch                     |
// |   inv        out  registered flag, synchronized Q equals Qbar            |
// +--------------------------------------------------------------------------+
module sr_latch_driver #(
  parameter int PULSE_W = 2,   // cycles S or R is held low, 1..15
  parameter int SETTLE  = 3    // idle cycles before readback, 2..15
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_bit,
  output logic req_ready,
  output logic S,
  output logic R,
  input  logic Q,
  input  logic Qbar,
  output logic done,
  output logic err,
  output logic inv
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PULSE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  // Counters are loaded with (length - 1) on state entry and leave the state
  // when they reach zero, so each state lasts exactly its configured length.
  localparam logic [3:0] PULSE_LOAD  = 4'(PULSE_W - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] cnt;
  logic [3:0] next_cnt;
  logic       wr_bit;
  logic       next_bit;
  logic       q_meta;
  logic       q_sync;
  logic       qb_meta;
  logic       qb_sync;
  logic       check_ok;

  // Next-state, counter and captured-bit logic.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_bit   = wr_bit;
    check_ok   = (q_sync == wr_bit) && (qb_sync == ~wr_bit);
    case (state)
      ST_IDLE: begin
        // req_ready is registered and held low in the first cycle after
        // reset, so gating on it keeps that cycle from accepting.
        if (req_valid && req_ready) begin
          next_bit   = req_bit;
          next_state = ST_PULSE;
          next_cnt   = PULSE_LOAD;
        end
      end
      ST_PULSE: begin
        if (cnt == 4'd0) begin
          next_state = ST_SETTLE;
          next_cnt   = SETTLE_LOAD;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      ST_SETTLE: begin
        if (cnt == 4'd0) begin
          next_state = ST_CHECK;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      ST_CHECK: begin
        next_state = ST_IDLE;
        next_cnt   = 4'd0;
      end
      default: begin
        next_state = ST_IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // State register plus all registered outputs. S/R are decoded from the
  // next state so the latch pulse starts in the cycle right after the accept
  // edge, while still coming straight out of flops. Only one of them can be
  // low because both depend on the same next_bit with opposite polarity.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      wr_bit    <= 1'b0;
      q_meta    <= 1'b0;
      q_sync    <= 1'b0;
      qb_meta   <= 1'b0;
      qb_sync   <= 1'b0;
      S         <= 1'b1;
      R         <= 1'b1;
      req_ready <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      inv       <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      wr_bit    <= next_bit;
      q_meta    <= Q;
      q_sync    <= q_meta;
      qb_meta   <= Qbar;
      qb_sync   <= qb_meta;
      S         <= ~((next_state == ST_PULSE) && !next_bit);
      R         <= ~((next_state == ST_PULSE) && next_bit);
      req_ready <= (next_state == ST_IDLE);
      done      <= (state == ST_CHECK) && check_ok;
      err       <= (state == ST_CHECK) && !check_ok;
      inv       <= (q_sync == qb_sync);
    end
  end

endmodule
`default_nettype wire
